gpio_bank: RTL

- Parametrised multi-port GPIO controller; successor to the fixed two-port, 8-bit GPIO.
- Exposes PORTS banks of WIDTH pins on the memory-mapped register bus.
- Each bank has:
  - Atomic set/clear writes.
  - A 2-flop input synchroniser.
  - Per-pin rising/falling edge interrupts with write-1-to-clear flags, merged into a single irq line for the core.

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/gpio_sync_edge.sv | 34 +++
 rtl/gpio_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared register offsets and select-width helper for the GPIO bank block.
// Pure declarations; no timing or flow control involved.
package gpio_pkg;

  localparam logic [2:0] GPIO_WR    = 3'd0;
  localparam logic [2:0] GPIO_DIR   = 3'd1;
  localparam logic [2:0] GPIO_RD    = 3'd2;
  localparam logic [2:0] GPIO_SET   = 3'd3;
  localparam logic [2:0] GPIO_CLR   = 3'd4;
  localparam logic [2:0] GPIO_IER   = 3'd5;
  localparam logic [2:0] GPIO_IEF   = 3'd6;
  localparam logic [2:0] GPIO_IFLAG = 3'd7;

  // regSel = {bank index, 3-bit offset}; at least one bank bit is always present.
  function automatic int gpio_sel_w(input int ports);
    int w;
    w = 3 + $clog2(ports);
    if (w < 4) w = 4;
    return w;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser plus history flop; sync_out lags the pin by 2 edges.
// Rise/fall are combinational from the synchronised value and its one-cycle history; no backpressure.
module gpio_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= pin_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_out = s2_q;
  assign rise     = s2_q & ~prev_q;
  assign fall     = ~s2_q & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// PORTS x WIDTH GPIO banks: register file, set/clear/W1C decode, tri-state pin drive, merged irq.
// Reads combinational from regSel, writes land on the rising clk edge; no backpressure.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int WIDTH = 8,
  parameter int SEL_W = gpio_sel_w(PORTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       regSel,
  input  logic                   we,
  input  logic [31:0]            di,
  output logic [31:0]            do_o,
  inout  wire  [PORTS*WIDTH-1:0] ports,
  output logic                   irq
);

  localparam int          BW      = SEL_W - 3;
  localparam logic [31:0] PORTS_U = PORTS;

  logic [BW-1:0]    bank_sel;
  logic [2:0]       off;
  logic             bank_ok;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] bank_rd [PORTS];
  logic [PORTS-1:0] bank_irq;
  logic             unused_di;

  assign bank_sel  = regSel[SEL_W-1:3];
  assign off       = regSel[2:0];
  assign bank_ok   = {{(32-BW){1'b0}}, bank_sel} < PORTS_U;
  assign wdat      = di[WIDTH-1:0];
  assign unused_di = ^di;

  assign do_o = bank_ok ? 32'(bank_rd[bank_sel]) : 32'd0;
  assign irq  = |bank_irq;

  for (genvar b = 0; b < PORTS; b++) begin : g_bank
    logic [WIDTH-1:0] wr_q, wr_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ier_q, ier_d;
    logic [WIDTH-1:0] ief_q, ief_d;
    logic [WIDTH-1:0] iflag_q, iflag_d;
    logic [WIDTH-1:0] sync_v, rise, fall, w1c, rdv;
    logic             hit;

    assign hit = we && bank_ok && (bank_sel == BW'(b));

    gpio_sync_edge #(.WIDTH(WIDTH)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .pin_in   (ports[b*WIDTH +: WIDTH]),
      .sync_out (sync_v),
      .rise     (rise),
      .fall     (fall)
    );

    always_comb begin
      wr_d  = wr_q;
      dir_d = dir_q;
      ier_d = ier_q;
      ief_d = ief_q;
      w1c   = '0;
      if (hit) begin
        case (off)
          GPIO_WR:    wr_d  = wdat;
          GPIO_DIR:   dir_d = wdat;
          GPIO_SET:   wr_d  = wr_q | wdat;
          GPIO_CLR:   wr_d  = wr_q & ~wdat;
          GPIO_IER:   ier_d = wdat;
          GPIO_IEF:   ief_d = wdat;
          GPIO_IFLAG: w1c   = wdat;
          default:    ;
        endcase
      end
      // New edges are OR'd in after the clear, so a coincident edge keeps its flag.
      iflag_d = (iflag_q & ~w1c) | (rise & ier_q) | (fall & ief_q);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_q    <= '0;
        dir_q   <= '0;
        ier_q   <= '0;
        ief_q   <= '0;
        iflag_q <= '0;
      end else begin
        wr_q    <= wr_d;
        dir_q   <= dir_d;
        ier_q   <= ier_d;
        ief_q   <= ief_d;
        iflag_q <= iflag_d;
      end
    end

    always_comb begin
      rdv = '0;
      case (off)
        GPIO_WR:    rdv = wr_q;
        GPIO_DIR:   rdv = dir_q;
        GPIO_RD:    rdv = sync_v;
        GPIO_IER:   rdv = ier_q;
        GPIO_IEF:   rdv = ief_q;
        GPIO_IFLAG: rdv = iflag_q;
        default:    rdv = '0;
      endcase
    end

    assign bank_rd[b]  = rdv;
    assign bank_irq[b] = |iflag_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign ports[b*WIDTH + i] = dir_q[i] ? wr_q[i] : 1'bz;
    end
  end

endmodule
